// File: rtl/niveles_sensor_if.sv
// Tank sensor front end: synchronises and debounces the float switches into level code A
// and raises/holds/releases fault code P with an acknowledge handshake on Pout.
module niveles_sensor_if #(
   parameter int DEB_CYCLES   = 4,
   parameter int FILL_TIMEOUT = 1000,
   parameter int HOLD_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_low,
   input  logic       s_high,
   input  logic [1:0] C,
   input  logic [1:0] Pout,
   output logic [1:0] A,
   output logic [1:0] P
);

   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int FW = $clog2(FILL_TIMEOUT);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(FILL_TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   localparam logic [1:0] ST_NORMAL   = 2'd0;
   localparam logic [1:0] ST_WAIT_ACK = 2'd1;
   localparam logic [1:0] ST_HOLD     = 2'd2;

   localparam logic [1:0] P_NONE   = 2'b00;
   localparam logic [1:0] P_SENSOR = 2'b01;
   localparam logic [1:0] P_TMO    = 2'b10;
   localparam logic [1:0] A_BAD    = 2'b10;

   logic [1:0]    raw;
   logic [1:0]    sync1_reg;
   logic [1:0]    sync2_reg;
   logic [1:0]    a_q;
   logic [1:0]    a_prev_reg;
   logic          a_changed;
   logic [FW-1:0] fill_cnt_reg;
   logic          tmo;
   logic          tmo_cause_reg;
   logic [1:0]    state_reg;
   logic [1:0]    p_reg;
   logic [HW-1:0] hcnt_reg;
   logic          cause_present;

   assign raw = {s_high, s_low};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg  <= 2'b00;
         sync2_reg  <= 2'b00;
         a_prev_reg <= 2'b00;
      end else begin
         sync1_reg  <= raw;
         sync2_reg  <= sync1_reg;
         a_prev_reg <= a_q;
      end
   end

   // One debouncer per switch; bit 1 is the high switch, bit 0 the low switch.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_deb
         logic          bit_reg;
         logic [DW-1:0] cnt_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               bit_reg <= 1'b0;
               cnt_reg <= '0;
            end else if (sync2_reg[gi] != bit_reg) begin
               if (cnt_reg == DEB_LAST) begin
                  bit_reg <= sync2_reg[gi];
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + DW'(1);
               end
            end else begin
               cnt_reg <= '0;
            end
         end

         assign a_q[gi] = bit_reg;
      end
   endgenerate

   // A "changed on the previous edge" restarts the fill watch and clears a pending timeout cause.
   assign a_changed = (a_q != a_prev_reg);
   assign tmo       = (C != 2'b00) && (fill_cnt_reg == FILL_LAST) && !a_changed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_cnt_reg  <= '0;
         tmo_cause_reg <= 1'b0;
      end else begin
         if (C == 2'b00 || a_changed) begin
            fill_cnt_reg  <= '0;
            tmo_cause_reg <= 1'b0;
         end else begin
            if (fill_cnt_reg != FILL_LAST)
               fill_cnt_reg <= fill_cnt_reg + FW'(1);
            if (tmo)
               tmo_cause_reg <= 1'b1;
         end
      end
   end

   assign cause_present = (p_reg == P_SENSOR) ? (a_q == A_BAD) : tmo_cause_reg;

   // A sensor fault pre-empts a pending timeout in any non-NORMAL state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_NORMAL;
         p_reg     <= P_NONE;
         hcnt_reg  <= '0;
      end else begin
         case (state_reg)
            ST_NORMAL: begin
               if (a_q == A_BAD) begin
                  p_reg     <= P_SENSOR;
                  state_reg <= ST_WAIT_ACK;
               end else if (tmo) begin
                  p_reg     <= P_TMO;
                  state_reg <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (p_reg == P_TMO && a_q == A_BAD) begin
                  p_reg <= P_SENSOR;
               end else if (Pout == p_reg) begin
                  hcnt_reg  <= '0;
                  state_reg <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (p_reg == P_TMO && a_q == A_BAD) begin
                  p_reg     <= P_SENSOR;
                  state_reg <= ST_WAIT_ACK;
               end else if (hcnt_reg == HOLD_LAST) begin
                  hcnt_reg <= '0;
                  if (!cause_present) begin
                     p_reg     <= P_NONE;
                     state_reg <= ST_NORMAL;
                  end
               end else begin
                  hcnt_reg <= hcnt_reg + HW'(1);
               end
            end
            default: begin
               p_reg     <= P_NONE;
               state_reg <= ST_NORMAL;
            end
         endcase
      end
   end

   assign A = a_q;
   assign P = p_reg;

endmodule

// File: tb/tb_niveles_sensor_if.sv
// Directed bench for niveles_sensor_if: debounce latency, glitch rejection, fault handshake,
// timeout, priority and mid-operation reset, each against hand-computed values.
module tb_niveles_sensor_if;

   logic       clk;
   logic       reset;
   logic       s_low;
   logic       s_high;
   logic [1:0] C;
   logic [1:0] Pout;
   logic [1:0] A;
   logic [1:0] P;

   int checks_cnt = 0;
   int errors_cnt = 0;

   niveles_sensor_if #(
      .DEB_CYCLES  (4),
      .FILL_TIMEOUT(16),
      .HOLD_CYCLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .s_low (s_low),
      .s_high(s_high),
      .C     (C),
      .Pout  (Pout),
      .A     (A),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s got=%b t=%0t", tag, got, $time);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      s_low  = 1'b1;
      s_high = 1'b1;
      C      = 2'b00;
      Pout   = 2'b00;

      // 1: asynchronous reset, then both switches accepted 5 edges after sync1 capture
      #1 reset = 1'b0;
      #1;
      check_val("rst_A_noedge", A, 2'b00);
      check_val("rst_P_noedge", P, 2'b00);
      tick(2);
      reset = 1'b1;
      tick(5);
      check_val("rel_A_edge5", A, 2'b00);
      tick(1);
      check_val("rel_A_edge6", A, 2'b11);

      // 2: a 3-sample pulse is rejected, a held level is accepted
      s_low  = 1'b0;
      s_high = 1'b0;
      tick(8);
      check_val("empty_A", A, 2'b00);
      s_low = 1'b1;
      tick(3);
      s_low = 1'b0;
      tick(8);
      check_val("glitch_A", A, 2'b00);
      s_low = 1'b1;
      tick(5);
      check_val("lowon_A_edge5", A, 2'b00);
      tick(1);
      check_val("lowon_A_edge6", A, 2'b01);

      // 3: inconsistent level raises 01, ack, then release once cause clears
      s_high = 1'b1;
      s_low  = 1'b0;
      tick(5);
      check_val("inc_A_pre", A, 2'b01);
      tick(1);
      check_val("inc_A", A, 2'b10);
      check_val("inc_P_pre", P, 2'b00);
      tick(1);
      check_val("inc_P", P, 2'b01);
      Pout = 2'b01;
      tick(1);
      s_high = 1'b0;
      tick(5);
      check_val("inc_hold_P", P, 2'b01);
      tick(1);
      check_val("inc_clear_A", A, 2'b00);
      tick(1);
      check_val("inc_hold_last_P", P, 2'b01);
      tick(1);
      check_val("inc_release_P", P, 2'b00);
      Pout = 2'b00;

      // 4: fill timeout after the 16th edge, held without ack, released after ack
      s_low = 1'b1;
      tick(8);
      check_val("mid_A", A, 2'b01);
      C = 2'b01;
      tick(15);
      check_val("tmo_P_edge15", P, 2'b00);
      tick(1);
      check_val("tmo_P_edge16", P, 2'b10);
      tick(100);
      check_val("tmo_noack_P", P, 2'b10);
      Pout = 2'b10;
      C    = 2'b00;
      tick(1);
      check_val("tmo_ack_P", P, 2'b10);
      tick(2);
      check_val("tmo_release_P", P, 2'b00);

      // 5: sensor fault pre-empts a timeout held in HOLD; a 10 echo does not ack it
      Pout = 2'b00;
      C    = 2'b01;
      tick(16);
      check_val("pri_tmo_P", P, 2'b10);
      Pout = 2'b10;
      tick(1);
      s_high = 1'b1;
      s_low  = 1'b0;
      tick(5);
      check_val("pri_hold_P", P, 2'b10);
      tick(1);
      check_val("pri_A", A, 2'b10);
      check_val("pri_P_pre", P, 2'b10);
      tick(1);
      check_val("pri_P", P, 2'b01);
      tick(5);
      check_val("pri_noack_P", P, 2'b01);

      // 6: asynchronous reset in WAIT_ACK
      #3 reset = 1'b0;
      #1;
      check_val("midrst_A", A, 2'b00);
      check_val("midrst_P", P, 2'b00);
      s_high = 1'b0;
      s_low  = 1'b0;
      C      = 2'b00;
      Pout   = 2'b00;
      #2 reset = 1'b1;
      tick(30);
      check_val("post_A", A, 2'b00);
      check_val("post_P", P, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
